// File: rtl/hit_judge.sv
// hit_judge: per-lane button conditioning, note judging and hit serialising
// for the score counter chain.
//
// Ports:
//   CLOCK    in  1  system clock, rising edge
//   RESET    in  1  asynchronous active-high reset
//   BTN      in  4  raw buttons (async), bit i = lane i
//   ARROW    in  4  hit-row occupancy, valid from the cycle after TICK
//   TICK     in  1  one-cycle playfield shift strobe
//   UP       out 1  one pulse per hit, never merged
//   MISS     out 1  pulse when any miss event was registered
//   HIT_LANE out 4  lanes judged as hits, one cycle wide
module hit_judge #(
  parameter int DEBOUNCE = 16
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [3:0] BTN,
  input  logic [3:0] ARROW,
  input  logic       TICK,
  output logic       UP,
  output logic       MISS,
  output logic [3:0] HIT_LANE
);

  typedef enum logic [1:0] {
    EMPTY,
    LIVE,
    SCORED
  } lane_t;

  localparam logic [7:0] LIM = 8'(DEBOUNCE - 1);

  logic [3:0] s1, s2, db, db_d, p;
  logic [7:0] cnt [4];

  lane_t st   [4];
  lane_t st_n [4];

  logic [3:0] hit, miss;
  logic [3:0] hit_r, miss_r;
  logic       tick_d;

  logic [2:0] pending, pend_n, pop;
  logic [3:0] sum;

  // Synchroniser and debounce: db only follows s2 after it has
  // disagreed for DEBOUNCE consecutive edges.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1   <= BTN;
      s2   <= s1;
      db_d <= db;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] != db[i]) begin
          if (cnt[i] == LIM) begin
            db[i]  <= s2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 8'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign p = db & ~db_d;

  // Lane judging. The tick_d cycle reloads every lane from the fresh
  // ARROW row; a press in that cycle is judged against the new row.
  always_comb begin
    hit  = '0;
    miss = '0;
    for (int i = 0; i < 4; i++) begin
      st_n[i] = st[i];
      if (tick_d) begin
        st_n[i] = ARROW[i] ? (p[i] ? SCORED : LIVE) : EMPTY;
        hit[i]  = p[i] & ARROW[i];
        miss[i] = (p[i] & ~ARROW[i]) |
                  (TICK & ARROW[i] & ~p[i]);
      end else begin
        unique case (st[i])
          LIVE: begin
            if (p[i]) begin
              hit[i]  = 1'b1;
              st_n[i] = SCORED;
            end else begin
              miss[i] = TICK;
            end
          end
          EMPTY:   miss[i] = p[i];
          default: ;
        endcase
      end
    end
  end

  // Serialiser: one UP per queued hit, saturating at 7.
  always_comb begin
    pop = {2'b0, hit[0]} + {2'b0, hit[1]} +
          {2'b0, hit[2]} + {2'b0, hit[3]};
    sum = {1'b0, pending} + {1'b0, pop} -
          {3'b0, |pending};
    pend_n = (sum > 4'd7) ? 3'd7 : sum[2:0];
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) st[i] <= EMPTY;
      tick_d   <= 1'b0;
      pending  <= '0;
      UP       <= 1'b0;
      hit_r    <= '0;
      miss_r   <= '0;
      HIT_LANE <= '0;
      MISS     <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) st[i] <= st_n[i];
      tick_d   <= TICK;
      pending  <= pend_n;
      UP       <= |pending;
      hit_r    <= hit;
      miss_r   <= miss;
      HIT_LANE <= hit_r;
      MISS     <= |miss_r;
    end
  end

endmodule
